// File: rtl/alu_4_pkg.sv
// Shared types and constants for the 4-bit ALU sequencer: opcodes, FSM states,
// widths and the opcode legality check.
package alu_4_pkg;

    localparam int OPW = 4;
    localparam int DW  = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_NOT_A  = 4'd4,
        OP_NAND   = 4'd5,
        OP_NOR    = 4'd6,
        OP_XOR    = 4'd7,
        OP_XNOR   = 4'd8,
        OP_MUL    = 4'd9
    } op_t;

    // Enum members must be unique, so the legal-range bound lives beside the enum.
    localparam op_t OP_LAST_LEGAL = OP_MUL;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/alu_4_seq_operand.sv
// Operand A select for the ALU sequencer; with ALU_4_SEQ_CHAIN_EN defined it also
// keeps last_y (low nibble of the last legal result) and chains it into A.
module alu_4_seq_operand #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] cmd_a,
    input  logic          cmd_chain,
    input  logic          capture,
    input  logic [DW-1:0] y_low,
    output logic [DW-1:0] a_sel
);

`ifdef ALU_4_SEQ_CHAIN_EN
    logic [DW-1:0] last_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_y <= '0;
        end else if (capture) begin
            last_y <= y_low;
        end
    end

    always_comb begin
        a_sel = cmd_chain ? last_y : cmd_a;
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{clk, rst, cmd_chain, capture, y_low};

    always_comb begin
        a_sel = cmd_a;
    end
`endif

endmodule

// File: rtl/alu_4_seq.sv
// Valid/ready sequencer driving one 4-bit combinational ALU and returning its result.
// Optional result chaining into operand A is enabled by defining ALU_4_SEQ_CHAIN_EN.
module alu_4_seq #(
    parameter int OPW = 4,
    parameter int DW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OPW-1:0]  cmd_op,
    input  logic [DW-1:0]   cmd_a,
    input  logic [DW-1:0]   cmd_b,
    input  logic            cmd_chain,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OPW-1:0]  alu_ctrl,
    input  logic [2*DW-1:0] alu_y,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [2*DW-1:0] res_data,
    output logic            res_err,
    output logic [7:0]      op_count
);
    import alu_4_pkg::*;

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          capture;
    logic          legal_ctrl;
    logic [DW-1:0] a_sel;

    assign accept     = cmd_valid && cmd_ready;
    assign capture    = (state == ST_DRIVE);
    assign legal_ctrl = is_legal_op(alu_ctrl);

    alu_4_seq_operand #(
        .DW(DW)
    ) u_operand (
        .clk       (clk),
        .rst       (rst),
        .cmd_a     (cmd_a),
        .cmd_chain (cmd_chain),
        .capture   (capture && legal_ctrl),
        .y_low     (alu_y[DW-1:0]),
        .a_sel     (a_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_DRIVE;
            ST_DRIVE: state_nxt = ST_RESP;
            ST_RESP: begin
                if (res_ready) begin
                    state_nxt = cmd_valid ? ST_DRIVE : ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A new command may only enter RESP's slot when the current result leaves.
    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: cmd_ready = !rst;
            ST_RESP: begin
                res_valid = 1'b1;
                cmd_ready = res_ready && !rst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept) begin
                alu_a    <= a_sel;
                alu_b    <= cmd_b;
                alu_ctrl <= cmd_op;
            end
            if (capture) begin
                res_data <= legal_ctrl ? alu_y : '0;
                res_err  <= !legal_ctrl;
            end
            if (res_valid && res_ready) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_4_seq.sv
// Scoreboard bench for alu_4_seq with a behavioural ALU attached to its A/B/CTRL -> Y port.
module tb_alu_4_seq;

`ifdef ALU_4_SEQ_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_chain;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;
    logic [7:0] op_count;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         passed = 0;
    int         total  = 0;
    logic [3:0] model_last_y = 4'h0;
    logic [7:0] exp_count = 8'h00;

    alu_4_seq #(.OPW(4), .DW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_chain (cmd_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Illegal opcodes return a nonzero pattern so forcing to 0x00 is observable.
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        case (op)
            4'd0: return {4'h0, a} + {4'h0, b};
            4'd1: return {4'h0, a} - {4'h0, b};
            4'd2: return {4'h0, a & b};
            4'd3: return {4'h0, a | b};
            4'd4: return {4'h0, ~a};
            4'd5: return {4'h0, ~(a & b)};
            4'd6: return {4'h0, ~(a | b)};
            4'd7: return {4'h0, a ^ b};
            4'd8: return {4'h0, ~(a ^ b)};
            4'd9: return {4'h0, a} * {4'h0, b};
            default: return 8'hAA;
        endcase
    endfunction

    always_comb alu_y = alu_fn(alu_a, alu_b, alu_ctrl);

    function automatic void push_expected(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic chain);
        exp_t       e;
        logic [3:0] eff_a;
        eff_a = (chain && CHAIN_EN) ? model_last_y : a;
        if (op <= 4'd9) begin
            e.data = alu_fn(eff_a, b, op);
            e.err  = 1'b0;
            model_last_y = e.data[3:0];
        end else begin
            e.data = 8'h00;
            e.err  = 1'b1;
        end
        sb.push_back(e);
    endfunction

    function automatic exp_t pop_expected();
        exp_t e;
        e.data = 8'hXX;
        e.err  = 1'bx;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    // Presents a command from a negedge; returns at the negedge of the DRIVE cycle.
    task automatic send_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic chain);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            total++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end else begin
            push_expected(op, a, b, chain);
        end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_chain = 1'b0;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            total++;
            $display("FAIL res_valid_timeout: res_valid=%b required 1", res_valid);
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_count = exp_count + 8'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready_in_rst: got %b want 0", cmd_ready); else passed++;
        rst = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready_after: got %b want 1", cmd_ready); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else passed++;
        total++; if ({res_data, res_err} !== 9'h000) $display("FAIL reset_res: got %h/%b want 00/0", res_data, res_err); else passed++;
        total++; if ({alu_a, alu_b, alu_ctrl} !== 12'h000) $display("FAIL reset_alu: got %h want 000", {alu_a, alu_b, alu_ctrl}); else passed++;
        total++; if (op_count !== 8'h00) $display("FAIL reset_op_count: got %h want 00", op_count); else passed++;
        @(negedge clk);
    endtask

    task automatic test_add();
        exp_t e;
        send_cmd(4'd0, 4'd7, 4'd9, 1'b0);
        total++; if ({alu_a, alu_b, alu_ctrl} !== 12'h790) $display("FAIL add_drive: got %h want 790", {alu_a, alu_b, alu_ctrl}); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL add_valid_early: got %b want 0", res_valid); else passed++;
        @(negedge clk);
        total++; if (res_valid !== 1'b1) $display("FAIL add_latency: res_valid got %b want 1", res_valid); else passed++;
        e = pop_expected();
        total++; if (res_data !== e.data || res_data !== 8'h10) $display("FAIL add_data: got %h want %h", res_data, e.data); else passed++;
        total++; if (res_err !== e.err) $display("FAIL add_err: got %b want %b", res_err, e.err); else passed++;
        handshake();
        total++; if (op_count !== exp_count) $display("FAIL add_op_count: got %h want %h", op_count, exp_count); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL add_idle: res_valid got %b want 0", res_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        res_ready = 1'b1;
        send_cmd(4'd9, 4'hF, 4'hF, 1'b0);
        cmd_valid = 1'b1; cmd_op = 4'd7; cmd_a = 4'hA; cmd_b = 4'h6;
        total++; if (cmd_ready !== 1'b0) $display("FAIL b2b_ready_in_drive: got %b want 0", cmd_ready); else passed++;
        @(negedge clk);
        e = pop_expected();
        total++; if (res_valid !== 1'b1 || res_data !== e.data || res_data !== 8'hE1) $display("FAIL b2b_mul: got %b/%h want 1/%h", res_valid, res_data, e.data); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_in_resp: got %b want 1", cmd_ready); else passed++;
        push_expected(4'd7, 4'hA, 4'h6, 1'b0);
        exp_count = exp_count + 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (res_valid !== 1'b0 || alu_ctrl !== 4'd7) $display("FAIL b2b_second_drive: got %b/%h want 0/7", res_valid, alu_ctrl); else passed++;
        @(negedge clk);
        e = pop_expected();
        total++; if (res_valid !== 1'b1 || res_data !== e.data || res_data !== 8'h0C) $display("FAIL b2b_xor: got %b/%h want 1/%h", res_valid, res_data, e.data); else passed++;
        exp_count = exp_count + 8'd1;
        @(negedge clk);
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0 || op_count !== exp_count) $display("FAIL b2b_count: got %b/%h want 0/%h", res_valid, op_count, exp_count); else passed++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        send_cmd(4'd2, 4'hC, 4'hA, 1'b0);
        wait_resp();
        e = pop_expected();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (res_valid !== 1'b1 || res_data !== e.data || cmd_ready !== 1'b0)
                $display("FAIL bp_hold_%0d: valid=%b data=%h ready=%b want 1/%h/0", i, res_valid, res_data, cmd_ready, e.data);
            else passed++;
            @(negedge clk);
        end
        handshake();
        total++; if (res_valid !== 1'b0 || op_count !== exp_count) $display("FAIL bp_release: got %b/%h want 0/%h", res_valid, op_count, exp_count); else passed++;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total++; if (op_count !== exp_count) $display("FAIL bp_ready_ignored: op_count got %h want %h", op_count, exp_count); else passed++;
    endtask

    task automatic test_illegal();
        exp_t e;
        send_cmd(4'hC, 4'd3, 4'd3, 1'b0);
        total++; if (alu_ctrl !== 4'hC) $display("FAIL illegal_ctrl: got %h want c", alu_ctrl); else passed++;
        wait_resp();
        e = pop_expected();
        total++; if (res_data !== e.data || res_err !== e.err || res_err !== 1'b1) $display("FAIL illegal_res: got %h/%b want %h/%b", res_data, res_err, e.data, e.err); else passed++;
        handshake();
        send_cmd(4'd0, 4'd3, 4'd4, 1'b0);
        wait_resp();
        e = pop_expected();
        total++; if (res_data !== 8'h07 || res_err !== 1'b0 || res_data !== e.data) $display("FAIL illegal_then_add: got %h/%b want 07/0", res_data, res_err); else passed++;
        handshake();
    endtask

    task automatic test_chain();
        exp_t e;
        logic [3:0] want_a;
        logic [7:0] want_y;
        want_a = CHAIN_EN ? 4'h7 : 4'hF;
        want_y = CHAIN_EN ? 8'h09 : 8'h11;
        send_cmd(4'd0, 4'd3, 4'd4, 1'b0);
        wait_resp();
        e = pop_expected();
        total++; if (res_data !== e.data) $display("FAIL chain_first: got %h want %h", res_data, e.data); else passed++;
        handshake();
        send_cmd(4'd0, 4'hF, 4'h2, 1'b1);
        total++; if (alu_a !== want_a || alu_b !== 4'h2) $display("FAIL chain_alu_a: got %h/%h want %h/2", alu_a, alu_b, want_a); else passed++;
        wait_resp();
        e = pop_expected();
        total++; if (res_data !== e.data || res_data !== want_y) $display("FAIL chain_result: got %h want %h", res_data, want_y); else passed++;
        handshake();
        total++; if (op_count !== exp_count) $display("FAIL chain_count: got %h want %h", op_count, exp_count); else passed++;
    endtask

    task automatic test_reset_mid();
        send_cmd(4'd0, 4'd1, 4'd1, 1'b0);
        rst = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        total++; if (res_valid !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL rstmid_valid: got %b/%b want 0/0", res_valid, cmd_ready); else passed++;
        total++; if ({res_data, res_err} !== 9'h000 || {alu_a, alu_b, alu_ctrl} !== 12'h000) $display("FAIL rstmid_regs: got %h/%b/%h want 0", res_data, res_err, {alu_a, alu_b, alu_ctrl}); else passed++;
        total++; if (op_count !== 8'h00) $display("FAIL rstmid_count: got %h want 00", op_count); else passed++;
        rst = 1'b0;
        res_ready = 1'b0;
        sb.delete();
        model_last_y = 4'h0;
        exp_count = 8'h00;
        @(negedge clk);
        total++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rstmid_idle: got %b/%b want 0/1", res_valid, cmd_ready); else passed++;
        send_cmd(4'd0, 4'hF, 4'h1, 1'b1);
        total++; if (alu_a !== (CHAIN_EN ? 4'h0 : 4'hF)) $display("FAIL rstmid_last_y: alu_a got %h want %h", alu_a, CHAIN_EN ? 4'h0 : 4'hF); else passed++;
        wait_resp();
        void'(pop_expected());
        handshake();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_chain();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_4_seq.md
# alu_4_seq

Sequencing front end for the 4-bit combinational ALU: accepts packed operation commands over a valid/ready stream, drives the ALU operand and control inputs from registers, captures the 8-bit result, and returns it over a second valid/ready stream. It is the initiator side of the ALU's A/B/CTRL → Y interface. It sits between a command source (test sequencer or microcode unit) and one ALU instance.

## Interface
- `OPW`, default 4: opcode width (`CTRL` width); fixed at 4.
- `DW`, default 4: operand width; the result is `2*DW`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on the cycle where `cmd_valid && cmd_ready`.
- `cmd_op`  in  4  opcode.
- `cmd_a`, `cmd_b`  in  4 each  operands.
- `cmd_chain`  in  1  use the previous result's low nibble as A; only active under the chain macro.
- `alu_a`, `alu_b`, `alu_ctrl`  out  4 each  registered drive to the ALU.
- `alu_y`  in  8  combinational ALU result.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts.
- `res_data`  out  8  captured result.
- `res_err`  out  1  illegal opcode.
- `op_count`  out  8  number of completed results; wraps 0xFF→0x00.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT A, 5 NAND, 6 NOR, 7 XOR, 8 XNOR, 9 MUL. 10–15 are illegal.
- FSM states:
  - IDLE: `cmd_ready`=1. Accept → DRIVE.
  - DRIVE: `alu_*` hold the command. At the end of the cycle, capture `alu_y` into `res_data` and go to RESP.
  - RESP: `res_valid`=1. If `res_ready`, the result handshake completes and `op_count` increments. If `cmd_valid` is also high, the new command is accepted (`cmd_ready`=`res_ready` in RESP) and the FSM goes → DRIVE. Otherwise it goes → IDLE.
- Illegal opcode: still passes through DRIVE. `alu_ctrl` is driven with the raw opcode. Captured `res_data` is forced to 0x00 and `res_err`=1.
- `alu_a`, `alu_b`, `alu_ctrl` change only on command accept and otherwise hold. Outside DRIVE they are don't-care to the ALU but stable.
- `res_data` and `res_err` are stable throughout RESP, including under back-pressure.
- `last_y` register (low nibble of the last legal result) updates on capture of a legal opcode only.

## Timing
- Accept at edge N. `alu_*` are valid from N+1. `res_valid` rises at N+2.
- Minimum latency is 2 cycles. Throughput is 1 result every 2 cycles with `res_ready` held high.
- Reset values:
  - state IDLE
  - `cmd_ready` 0 while `rst` is high, 1 in the first cycle after
  - `res_valid` 0
  - `res_data` 0x00
  - `res_err` 0
  - `alu_a`, `alu_b`, `alu_ctrl` 0
  - `last_y` 0
  - `op_count` 0
- Reset mid-operation (DRIVE or RESP) discards the in-flight result. No handshake completes in the reset cycle.
- `res_ready` asserted while `res_valid`=0 is ignored.
- `cmd_valid` is ignored in DRIVE.

## Configuration
- `ALU_4_SEQ_CHAIN_EN` defined: on accept with `cmd_chain`=1, `alu_a` is loaded from `last_y`, not `cmd_a`. `cmd_b` is used as-is.
- Not defined: `cmd_chain` is ignored, `last_y` is not built, and `alu_a` is always `cmd_a`.

## Structure
- Shared package `alu_4_pkg`:
  - opcode enum typedef (values 0–9, plus `OP_LAST_LEGAL`=9)
  - FSM state enum (IDLE/DRIVE/RESP)
  - width constants `OPW`, `DW`
  - `is_legal_op()` function
- One sub-module, `alu_4_seq_operand`: the operand select mux and `last_y` register. It is compiled in or out by the macro; this keeps the FSM and handshake logic in the top level free of conditional code.

## Test plan
- ADD: `cmd_op`=0, A=7, B=9 → `res_data`=0x10 at accept+2, `res_err`=0, `op_count`=1 after handshake.
- MUL and XOR back-to-back with `res_ready`=1: 15×15 → 0xE1, then 0xA XOR 0x6 → 0x0C. Second accept occurs in the first result's RESP cycle; results are 2 cycles apart.
- Back-pressure: `res_ready`=0 for 5 cycles in RESP → `res_data` and `res_valid` stable, `cmd_ready`=0. Then `res_ready`=1 → single handshake and `op_count` +1 only once.
- Illegal opcode 0xC with A=3, B=3 → `res_data`=0x00, `res_err`=1. A following ADD 3+4 → 0x07 with `res_err`=0.
- Chain (macro on): ADD 3+4 → 0x07, then ADD `cmd_chain`=1, A=0xF, B=2 → `alu_a`=7, result 0x09. Macro off: same stimulus → 0x11.
- Reset asserted in DRIVE → no `res_valid`, all outputs at reset values next cycle, `op_count`=0.
